// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS-subset core: fetch, decode, execute, memory strobes and
// writeback all resolve within one clock; only the PC and register file hold state.
module single_cycle_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic [31:0] memOut,
   output logic [31:0] PCvalue,
   output logic [31:0] aluRes,
   output logic [31:0] readData1,
   output logic        memRead_en,
   output logic        memWrite_en
);
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] F_ADD    = 6'h20;
   localparam logic [5:0] F_SUB    = 6'h22;
   localparam logic [5:0] F_AND    = 6'h24;
   localparam logic [5:0] F_OR     = 6'h25;
   localparam logic [5:0] F_SLT    = 6'h2A;

   logic [31:0] pc_q, pc_d;
   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [25:0] target;
   logic [31:0] rs_val, rt_val, sext_imm, pc_plus4, alu;
   logic        we, mem_rd, mem_wr;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        unused_shamt;

   assign op           = inst[31:26];
   assign rs           = inst[25:21];
   assign rt           = inst[20:16];
   assign rd           = inst[15:11];
   assign funct        = inst[5:0];
   assign imm          = inst[15:0];
   assign target       = inst[25:0];
   assign unused_shamt = ^inst[10:6];

   assign rs_val   = (rs == 5'd0) ? 32'd0 : regs_q[rs];
   assign rt_val   = (rt == 5'd0) ? 32'd0 : regs_q[rt];
   assign sext_imm = {{16{imm[15]}}, imm};
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      alu    = 32'd0;
      we     = 1'b0;
      wa     = rd;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      pc_d   = pc_plus4;
      case (op)
         OP_RTYPE: begin
            we = 1'b1;
            case (funct)
               F_ADD:   alu = rs_val + rt_val;
               F_SUB:   alu = rs_val - rt_val;
               F_AND:   alu = rs_val & rt_val;
               F_OR:    alu = rs_val | rt_val;
               F_SLT:   alu = {31'd0, $signed(rs_val) < $signed(rt_val)};
               default: we  = 1'b0;
            endcase
         end
         OP_ADDI: begin
            alu = rs_val + sext_imm;
            we  = 1'b1;
            wa  = rt;
         end
         OP_LW: begin
            alu    = rs_val + sext_imm;
            we     = 1'b1;
            wa     = rt;
            mem_rd = 1'b1;
         end
         OP_SW: begin
            alu    = rs_val + sext_imm;
            mem_wr = 1'b1;
         end
         OP_BEQ: begin
            // zero difference means the branch is taken
            alu = rs_val - rt_val;
            if (rs_val == rt_val) pc_d = pc_plus4 + {sext_imm[29:0], 2'b00};
         end
         OP_J:    pc_d = {pc_plus4[31:28], target, 2'b00};
         default: ;
      endcase
   end

   assign wd = mem_rd ? memOut : alu;

   always_comb begin
      regs_d = regs_q;
      if (we && wa != 5'd0) regs_d[wa] = wd;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
      end else begin
         pc_q   <= pc_d;
         regs_q <= regs_d;
      end
   end

   assign PCvalue     = pc_q;
   assign aluRes      = alu;
   assign readData1   = rt_val;
   // strobes are gated so memory sees nothing while reset is held
   assign memRead_en  = rst & mem_rd;
   assign memWrite_en = rst & mem_wr;
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed plus random bench for single_cycle_cpu against an ISA-level
// reference model (architectural registers, PC and data memory).
module tb_single_cycle_cpu;
   logic        clk, rst;
   logic [31:0] inst, memOut, PCvalue, aluRes, readData1;
   logic        memRead_en, memWrite_en;

   logic [31:0] dmem [16];
   logic [31:0] ref_mem [16];
   logic [31:0] ref_reg [32];
   logic [31:0] ref_pc;
   logic [31:0] last_alu, last_rd1;
   int vectors = 0;
   int errors  = 0;

   single_cycle_cpu #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .inst(inst), .memOut(memOut),
      .PCvalue(PCvalue), .aluRes(aluRes), .readData1(readData1),
      .memRead_en(memRead_en), .memWrite_en(memWrite_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // data memory: combinational read, write on the clock edge
   assign memOut = dmem[aluRes[5:2]];
   always @(posedge clk) if (rst && memWrite_en) dmem[aluRes[5:2]] <= readData1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic ref_reset();
      ref_pc = 32'h0;
      for (int i = 0; i < 32; i++) ref_reg[i] = 32'd0;
   endtask

   // Apply one instruction (called just after a falling edge), check, retire.
   task automatic step(input logic [31:0] ins);
      logic [5:0]  op, fn;
      logic [4:0]  s, t, d, wa;
      logic [31:0] a, b, se, e_alu, n_pc, wd;
      logic        alu_def, e_mr, e_mw, wr;
      inst = ins;
      #1;
      op = ins[31:26]; fn = ins[5:0];
      s = ins[25:21]; t = ins[20:16]; d = ins[15:11];
      a = ref_reg[s]; b = ref_reg[t];
      se = {{16{ins[15]}}, ins[15:0]};
      e_alu = 32'd0; alu_def = 1'b1; e_mr = 1'b0; e_mw = 1'b0;
      wr = 1'b0; wa = d; wd = 32'd0; n_pc = ref_pc + 32'd4;
      if (op == 6'h00) begin
         wr = 1'b1;
         if (fn == 6'h20) e_alu = a + b;
         else if (fn == 6'h22) e_alu = a - b;
         else if (fn == 6'h24) e_alu = a & b;
         else if (fn == 6'h25) e_alu = a | b;
         else if (fn == 6'h2A) e_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         else wr = 1'b0;
         wd = e_alu;
      end else if (op == 6'h08) begin
         e_alu = a + se; wr = 1'b1; wa = t; wd = e_alu;
      end else if (op == 6'h23) begin
         e_alu = a + se; e_mr = 1'b1; wr = 1'b1; wa = t; wd = ref_mem[e_alu[5:2]];
      end else if (op == 6'h2B) begin
         e_alu = a + se; e_mw = 1'b1;
      end else if (op == 6'h04) begin
         alu_def = 1'b0;
         if (a == b) n_pc = ref_pc + 32'd4 + se * 4;
      end else if (op == 6'h02) begin
         alu_def = 1'b0;
         n_pc = {n_pc[31:28], ins[25:0], 2'b00};
      end
      chk("pc", PCvalue, ref_pc);
      chk("rdata1", readData1, b);
      chk("mem_rd", {31'd0, memRead_en}, {31'd0, e_mr});
      chk("mem_wr", {31'd0, memWrite_en}, {31'd0, e_mw});
      if (alu_def) chk("alu", aluRes, e_alu);
      last_alu = aluRes;
      last_rd1 = readData1;
      @(posedge clk);
      if (wr && wa != 5'd0) ref_reg[wa] = wd;
      if (e_mw) ref_mem[e_alu[5:2]] = b;
      ref_pc = n_pc;
      @(negedge clk);
   endtask

   // Reset pulse between edges; PC must clear without a clock edge.
   task automatic async_reset();
      #3 rst = 1'b0;
      #1 chk("arst_pc", PCvalue, 32'h0);
      ref_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [5:0] fn;
      logic [15:0] imm;
      logic [4:0] s, t, d;
      int v;
      logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      logic [5:0] bad_ops [5] = '{6'h01, 6'h03, 6'h05, 6'h0C, 6'h3F};
      s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case ($urandom_range(0, 11))
         0, 1, 2: return {6'h00, s, t, d, 5'd0, fns[$urandom_range(0, 4)]};
         3, 4:    return {6'h08, s, t, imm};
         5:       return {6'h23, 5'd0, 5'($urandom_range(1, 7)), 16'($urandom_range(0, 15) * 4)};
         6:       return {6'h2B, 5'd0, t, 16'($urandom_range(0, 15) * 4)};
         7: begin
            v = $urandom_range(0, 8) - 4;
            return {6'h04, s, t, v[15:0]};
         end
         8:       return {6'h02, 26'($urandom)};
         9: begin
            do fn = 6'($urandom); while (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
            return {6'h00, s, t, d, 5'd0, fn};
         end
         default: return {bad_ops[$urandom_range(0, 4)], 26'($urandom)};
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) begin dmem[i] = 32'd0; ref_mem[i] = 32'd0; end
      ref_reset();
      rst = 1'b0;
      inst = 32'h8C04_0004;
      repeat (3) @(negedge clk);
      chk("rst_pc", PCvalue, 32'h0);
      chk("rst_mrd", {31'd0, memRead_en}, 32'd0);
      inst = 32'hAC03_0004;
      #1 chk("rst_mwr", {31'd0, memWrite_en}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step(32'h0000_0000);
      chk("rel_pc", PCvalue, 32'h4);

      async_reset();
      step(32'h2001_0005);
      step(32'h2002_0007);
      step(32'h0022_1820);
      chk("add12", last_alu, 32'd12);
      chk("pc_c", PCvalue, 32'hC);
      step(32'hAC03_0004);
      chk("sw_addr", last_alu, 32'd4);
      chk("sw_data", last_rd1, 32'd12);
      step(32'h1021_0002);
      chk("beq_taken", PCvalue, 32'h1C);
      step(32'h8C04_0004);
      step(32'h0080_2820);
      chk("lw_val", last_alu, 32'd12);
      step(32'h0041_4022);
      chk("sub", last_alu, 32'd2);
      step(32'h0022_482A);
      chk("slt", last_alu, 32'd1);
      step(32'h1022_0002);
      chk("beq_not", PCvalue, 32'h30);
      step(32'h0800_0004);
      chk("jump", PCvalue, 32'h10);
      step(32'h2000_0009);
      step(32'h0000_3820);
      chk("reg0", last_alu, 32'd0);
      async_reset();
      step(32'h0020_3020);
      chk("arst_reg", last_alu, 32'd0);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 59) == 0) async_reset();
         step(rand_inst());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/single_cycle_cpu.md
Name: single_cycle_cpu

Overview:
- 32-bit single-cycle MIPS-subset processor core with a Harvard-style interface.
- Fetches one instruction per clock from an external instruction/data memory using PCvalue.
- Computes ALU results and issues combinational data-memory read/write strobes.
- Sits between the clock generator and the unified memory model in the system-level bench.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- inst  input  32  instruction word fetched from memory at PCvalue.
- memOut  input  32  data read from memory at aluRes; combinational, valid the same cycle.
- PCvalue  output  32  current program counter (byte address).
- aluRes  output  32  ALU result; also the data-memory address for lw/sw.
- readData1  output  32  store data = register[rt] contents; written to memory by sw.
- memRead_en  output  1  high during lw.
- memWrite_en  output  1  high during sw.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC <= RESET_PC; all 32 registers <= 0.
  - memRead_en = memWrite_en = 0 while rst=0.
  - aluRes and readData1 follow the combinational path, which is zero-valued after clearing.
- Register file:
  - 32x32; two combinational read ports (rs, rt); one write port on the rising clk edge.
  - $0 reads 0; writes to $0 are ignored.
- Instruction fields:
  - op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], target[25:0].
  - imm is sign-extended.
- Supported instructions:
  - R-type (op=0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A. Result is written to rd.
  - addi op=0x08: rt <= rs + sext(imm).
  - lw op=0x23:
    - aluRes = rs + sext(imm); memRead_en=1.
    - rt <= memOut at the clock edge.
  - sw op=0x2B:
    - aluRes = rs + sext(imm); readData1 = reg[rt]; memWrite_en=1.
    - No register write.
  - beq op=0x04: if reg[rs]==reg[rt], PC <= PC+4+(sext(imm)<<2); otherwise PC <= PC+4.
  - j op=0x02: PC <= {PC+4[31:28], target, 2'b00}.
- Unknown op or funct:
  - Treated as NOP: no register write, no memory strobes, PC <= PC+4.
  - aluRes = 0.
- Timing:
  - Every instruction completes in exactly one cycle; there are no stalls or hazards.
  - Next PC defaults to PC+4 and wraps modulo 2^32.
- Arithmetic:
  - add, sub and addi are 32-bit two's complement with wraparound; no overflow trap.
  - slt is a signed compare yielding 1 or 0.
- Strobes:
  - memRead_en and memWrite_en are combinational decodes of the current inst.
  - They are never both high in the same cycle.
- Reset mid-operation:
  - Asserting rst at any time immediately forces PC to RESET_PC and clears the registers.
  - The instruction in flight does not commit.
- First cycle after release:
  - On the first rising edge after rst returns high, the instruction at RESET_PC executes.

Test Plan:
- Reset: hold rst=0 with clk running.
  - PCvalue=0, memRead_en=0, memWrite_en=0.
  - Release rst: after one edge PCvalue=4.
- ALU sequence: inst 0x20010005 (addi $1,$0,5), 0x20020007 (addi $2,$0,7), 0x00221820 (add $3,$1,$2).
  - aluRes=12 on the third cycle; PC advances 0, 4, 8, 12.
  - sub/slt variants: $2-$1=2, slt($1,$2)=1.
- Store/load: inst 0xAC030004 (sw $3,4($0)), then 0x8C040004 (lw $4,4($0)).
  - sw cycle: aluRes=4, readData1=12, memWrite_en=1.
  - lw cycle: memRead_en=1, and $4=12 afterward, checked by a following add $5,$4,$0 giving aluRes=12.
- Branch: with $1=5, beq $1,$1,+2 (0x10210002) at PC=0x10 -> next PC=0x1C.
  - beq $1,$2 with unequal values -> next PC=0x14.
- Jump: 0x08000004 at any PC below 0x1000_0000 -> next PC=0x10.
- Async reset mid-run: drive rst=0 between clock edges.
  - PCvalue becomes 0 without waiting for a clk edge.
  - A subsequent read of $1 via add $6,$1,$0 yields aluRes=0.
- Register $0: addi $0,$0,9 -> $0 remains 0, verified with add $7,$0,$0 giving aluRes=0.
